// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the multi-cycle RISC-V sequencer.
package cpu_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_BOOT   = 4'd1,
        ST_FETCH  = 4'd2,
        ST_DECODE = 4'd3,
        ST_EXEC   = 4'd4,
        ST_MEM    = 4'd5,
        ST_WB     = 4'd6,
        ST_DONE   = 4'd7,
        ST_ERROR  = 4'd8
    } seq_state_t;

    localparam logic [6:0] OP_R   = 7'h33;
    localparam logic [6:0] OP_I   = 7'h13;
    localparam logic [6:0] OP_LW  = 7'h03;
    localparam logic [6:0] OP_S   = 7'h23;
    localparam logic [6:0] OP_SB  = 7'h63;
    localparam logic [6:0] OP_JAL = 7'h6F;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Control bundle latched in DECODE and consumed by EXEC/MEM/WB.
    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src;
        logic       mem2reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       is_branch;
        logic       is_jump;
    } seq_ctrl_t;

endpackage

// File: rtl/cpu_seq_decode.sv
// Combinational opcode decode: instruction word to control bundle plus illegal flag.
module cpu_seq_decode
    import cpu_seq_pkg::*;
(
    input  logic [31:0] ins,
    output seq_ctrl_t   ctrl,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;

    assign opcode    = ins[6:0];
    assign funct3    = ins[14:12];
    assign funct7_b5 = ins[30];

    // Register fields are the datapath's business, not the sequencer's.
    logic unused_fields;
    assign unused_fields = ^{ins[31], ins[29:15], ins[11:7]};

    // Decode opcode/funct fields; anything unrecognised is flagged illegal.
    always_comb begin
        ctrl    = '0;
        illegal = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl.reg_write = 1'b1;
                case (funct3)
                    3'b000:  ctrl.alu_op = funct7_b5 ? ALU_SUB : ALU_ADD;
                    3'b111:  ctrl.alu_op = ALU_AND;
                    3'b110:  ctrl.alu_op = ALU_OR;
                    3'b010:  ctrl.alu_op = ALU_SLT;
                    default: ctrl.alu_op = ALU_ADD;
                endcase
            end
            OP_I: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_LW: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = 1'b1;
                ctrl.mem2reg   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.mem_read  = 1'b1;
            end
            OP_S: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OP_SB: begin
                ctrl.alu_op    = ALU_SUB;
                ctrl.is_branch = 1'b1;
            end
            OP_JAL: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.reg_write = 1'b1;
                ctrl.is_jump   = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle sequencer: BOOT, FETCH, DECODE, EXEC, optional MEM, WB.
// Optional cycle counter enabled by defining CPU_SEQ_CYCLE_CNT_EN.
module cpu_seq_ctrl
    import cpu_seq_pkg::*;
#(
    parameter int MAX_INS     = 43,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      ins,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             boot,
    output logic             pc_en,
    output logic             fetch_en,
    output logic [2:0]       alu_op,
    output logic             alu_src,
    output logic             mem2reg,
    output logic             reg_write,
    output logic             mem_req,
    output logic             mem_read,
    output logic             mem_write,
    output logic             is_branch,
    output logic             is_jump,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] ins_count,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    seq_state_t        state_reg, state_next;
    seq_ctrl_t         dec_ctrl, ctrl_reg;
    logic              dec_illegal;
    logic [WAIT_W-1:0] wait_reg, wait_next;
    logic [CNT_W-1:0]  ins_count_reg;
    logic              last_ins;

    logic boot_reg, pc_en_reg, fetch_en_reg, reg_write_reg;
    logic mem_req_reg, mem_read_reg, mem_write_reg;
    logic is_branch_reg, is_jump_reg, busy_reg, done_reg, err_reg;
    logic boot_next, pc_en_next, fetch_en_next, reg_write_next;
    logic mem_req_next, mem_read_next, mem_write_next;
    logic is_branch_next, is_jump_next, busy_next, done_next, err_next;

    // The zero flag is consumed by yPC directly alongside is_branch.
    logic unused_zero;
    assign unused_zero = zero;

    cpu_seq_decode u_decode (
        .ins     (ins),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    assign last_ins = (ins == 32'h0) ||
                      ((MAX_INS != 0) && ((ins_count_reg + CNT_W'(1)) == CNT_W'(MAX_INS)));

    // Next-state logic and registered-output precomputation from the next state.
    always_comb begin
        state_next = state_reg;
        wait_next  = wait_reg;
        case (state_reg)
            ST_IDLE:   if (start) state_next = ST_BOOT;
            ST_BOOT:   state_next = ST_FETCH;
            ST_FETCH:  state_next = ST_DECODE;
            ST_DECODE: state_next = dec_illegal ? ST_ERROR : ST_EXEC;
            ST_EXEC: begin
                wait_next  = '0;
                state_next = (ctrl_reg.mem_read || ctrl_reg.mem_write) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                // An ack on the final allowed cycle still wins over the timeout.
                if (mem_ack)
                    state_next = ST_WB;
                else if (wait_reg == WAIT_W'(MEM_TIMEOUT - 1))
                    state_next = ST_ERROR;
                else
                    wait_next = wait_reg + WAIT_W'(1);
            end
            ST_WB:     state_next = last_ins ? ST_DONE : ST_FETCH;
            ST_DONE:   state_next = ST_DONE;
            ST_ERROR:  state_next = ST_ERROR;
            default:   state_next = ST_ERROR;
        endcase

        boot_next      = (state_next == ST_BOOT);
        pc_en_next     = (state_next == ST_BOOT) || (state_next == ST_WB);
        fetch_en_next  = (state_next == ST_FETCH);
        reg_write_next = (state_next == ST_WB) && ctrl_reg.reg_write;
        is_branch_next = (state_next == ST_WB) && ctrl_reg.is_branch;
        is_jump_next   = (state_next == ST_WB) && ctrl_reg.is_jump;
        mem_req_next   = (state_next == ST_MEM);
        mem_read_next  = (state_next == ST_MEM) && ctrl_reg.mem_read;
        mem_write_next = (state_next == ST_MEM) && ctrl_reg.mem_write;
        busy_next      = (state_next != ST_IDLE) && (state_next != ST_DONE) &&
                         (state_next != ST_ERROR);
        done_next      = (state_next == ST_DONE);
        err_next       = (state_next == ST_ERROR);
    end

    // State, handshake wait counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            wait_reg      <= '0;
            boot_reg      <= 1'b0;
            pc_en_reg     <= 1'b0;
            fetch_en_reg  <= 1'b0;
            reg_write_reg <= 1'b0;
            is_branch_reg <= 1'b0;
            is_jump_reg   <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wait_reg      <= wait_next;
            boot_reg      <= boot_next;
            pc_en_reg     <= pc_en_next;
            fetch_en_reg  <= fetch_en_next;
            reg_write_reg <= reg_write_next;
            is_branch_reg <= is_branch_next;
            is_jump_reg   <= is_jump_next;
            mem_req_reg   <= mem_req_next;
            mem_read_reg  <= mem_read_next;
            mem_write_reg <= mem_write_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
        end
    end

    // Latch decoded controls once per instruction; they stay stable through WB.
    always_ff @(posedge clk) begin
        if (rst)
            ctrl_reg <= '0;
        else if (state_reg == ST_DECODE && !dec_illegal)
            ctrl_reg <= dec_ctrl;
    end

    // Retired-instruction counter, bumped on leaving WB, saturating.
    always_ff @(posedge clk) begin
        if (rst)
            ins_count_reg <= '0;
        else if (state_reg == ST_WB && ins_count_reg != '1)
            ins_count_reg <= ins_count_reg + CNT_W'(1);
    end

`ifdef CPU_SEQ_CYCLE_CNT_EN
    logic [CNT_W-1:0] cycle_count_reg;

    // Busy-cycle counter, saturating.
    always_ff @(posedge clk) begin
        if (rst)
            cycle_count_reg <= '0;
        else if (busy_reg && cycle_count_reg != '1)
            cycle_count_reg <= cycle_count_reg + CNT_W'(1);
    end

    assign cycle_count = cycle_count_reg;
`else
    assign cycle_count = '0;
`endif

    assign boot      = boot_reg;
    assign pc_en     = pc_en_reg;
    assign fetch_en  = fetch_en_reg;
    assign alu_op    = ctrl_reg.alu_op;
    assign alu_src   = ctrl_reg.alu_src;
    assign mem2reg   = ctrl_reg.mem2reg;
    assign reg_write = reg_write_reg;
    assign mem_req   = mem_req_reg;
    assign mem_read  = mem_read_reg;
    assign mem_write = mem_write_reg;
    assign is_branch = is_branch_reg;
    assign is_jump   = is_jump_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    assign ins_count = ins_count_reg;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl (built with MAX_INS=3).
module tb_cpu_seq_ctrl;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [31:0]      ins;
    logic             zero;
    logic             mem_ack;
    logic             boot, pc_en, fetch_en, alu_src, mem2reg, reg_write;
    logic             mem_req, mem_read, mem_write, is_branch, is_jump;
    logic             busy, done, err;
    logic [2:0]       alu_op;
    logic [CNT_W-1:0] ins_count, cycle_count;

    int n_cmp = 0;
    int n_bad = 0;
    int n_tick, n_req, n_rd, n_wr, n_rw, fe_at;

    localparam logic [31:0] INS_SUB  = 32'h402081B3; // sub x3,x1,x2
    localparam logic [31:0] INS_LW   = 32'h0040A103; // lw  x2,4(x1)
    localparam logic [31:0] INS_SW   = 32'h0020A223; // sw  x2,4(x1)
    localparam logic [31:0] INS_ADDI = 32'h00108093; // addi x1,x1,1
    localparam logic [31:0] INS_BAD  = 32'h0000007F;

    always #5 clk = ~clk;

    cpu_seq_ctrl #(.MAX_INS(3), .MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .ins(ins), .zero(zero),
        .mem_ack(mem_ack), .boot(boot), .pc_en(pc_en), .fetch_en(fetch_en),
        .alu_op(alu_op), .alu_src(alu_src), .mem2reg(mem2reg),
        .reg_write(reg_write), .mem_req(mem_req), .mem_read(mem_read),
        .mem_write(mem_write), .is_branch(is_branch), .is_jump(is_jump),
        .busy(busy), .done(done), .err(err), .ins_count(ins_count),
        .cycle_count(cycle_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, then present start for one edge so BOOT is entered.
    task automatic boot_with(input logic [31:0] word, input logic keep_start);
        rst = 1'b1; start = 1'b0; mem_ack = 1'b0; ins = word;
        tick(); tick();
        rst = 1'b0; start = 1'b1;
        tick();
        chk("boot_pulse", {boot, pc_en, busy}, 3'b111);
        start = keep_start;
    endtask

    // Step until WB (pc_en) or until done/err, counting strobes along the way.
    task automatic run_to(input bit until_end, input int ack_at, input int limit);
        bit stopped = 1'b0;
        n_tick = 0; n_req = 0; n_rd = 0; n_wr = 0; n_rw = 0; fe_at = 0;
        for (int i = 0; i < limit && !stopped; i++) begin
            tick();
            n_tick++;
            if (fetch_en && fe_at == 0) fe_at = n_tick;
            if (mem_req)   n_req++;
            if (mem_read)  n_rd++;
            if (mem_write) n_wr++;
            if (reg_write) n_rw++;
            mem_ack = (ack_at != 0) && mem_req && (n_req == ack_at);
            if (until_end ? (done || err) : (pc_en || err)) stopped = 1'b1;
        end
        mem_ack = 1'b0;
        chk("run_bound", {31'd0, stopped}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; ins = INS_SUB; zero = 1'b0; mem_ack = 1'b0;

        // Reset dominates even with start high.
        tick(); tick();
        chk("reset_outs", {boot, pc_en, fetch_en, alu_op, alu_src, mem2reg, reg_write,
                           mem_req, mem_read, mem_write, is_branch, is_jump,
                           busy, done, err}, 32'd0);
        chk("reset_cnts", {ins_count, cycle_count}, 32'd0);

        // R-type sub.
        boot_with(INS_SUB, 1'b0);
        run_to(1'b0, 0, 10);
        chk("sub_fetch_at", fe_at, 1);
        chk("sub_wb_tick", n_tick, 4);
        chk("sub_alu_op", alu_op, 3'b110);
        chk("sub_wb_ctl", {reg_write, pc_en, alu_src, mem2reg, busy}, 5'b11001);
        tick();
        chk("sub_retired", ins_count, 1);
        chk("sub_refetch", {fetch_en, reg_write}, 2'b10);

        // lw, ack in the fourth MEM cycle.
        boot_with(INS_LW, 1'b0);
        run_to(1'b0, 4, 20);
        chk("lw_total", n_tick, 8);
        chk("lw_req_rd_wr", {n_req[7:0], n_rd[7:0], n_wr[7:0]}, {8'd4, 8'd4, 8'd0});
        chk("lw_wb_ctl", {reg_write, mem2reg, alu_src, alu_op, mem_req}, 7'b1110100);
        chk("lw_rw_count", n_rw, 1);

        // Reset in the middle of a MEM handshake.
        boot_with(INS_LW, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        chk("mid_mem_req", {mem_req, mem_read}, 2'b11);
        rst = 1'b1;
        tick();
        chk("mid_mem_rst", {mem_req, mem_read, busy}, 3'b000);
        rst = 1'b0;

        // sw never acknowledged: timeout.
        boot_with(INS_SW, 1'b0);
        run_to(1'b1, 0, 40);
        chk("sw_mem_cycles", {n_req[7:0], n_wr[7:0], n_rd[7:0]}, {8'd15, 8'd15, 8'd0});
        chk("sw_err_tick", n_tick, 19);
        chk("sw_err_state", {err, mem_req, mem_write, busy, done}, 5'b10000);
        tick(); tick();
        chk("sw_err_hold", err, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("sw_rst_clear", {err, busy, done}, 3'b000);

        // Illegal opcode traps straight out of DECODE.
        boot_with(INS_BAD, 1'b0);
        run_to(1'b1, 0, 20);
        chk("bad_err_tick", n_tick, 3);
        chk("bad_no_rw", n_rw, 0);
        chk("bad_err", {err, busy, ins_count}, {2'b10, 16'd0});

        // Three addi with the budget at 3; start kept high throughout.
        boot_with(INS_ADDI, 1'b1);
        run_to(1'b1, 0, 40);
        chk("addi_ticks", n_tick, 13);
        chk("addi_rw_count", n_rw, 3);
        chk("addi_done", {done, busy, err, alu_op, alu_src}, 7'b1000101);
        chk("addi_count", ins_count, 3);
`ifdef CPU_SEQ_CYCLE_CNT_EN
        chk("addi_cycles", cycle_count, 13);
`else
        chk("addi_cycles", cycle_count, 0);
`endif
        tick(); tick(); tick();
        chk("done_hold", {done, busy, boot, fetch_en, ins_count}, {4'b1000, 16'd3});

        start = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
Multi-cycle sequencer for the single-cycle RISC-V datapath (yIF, yID, yEX, yDM, yWB, yPC). It replaces testbench-driven clocking and opcode decoding. It steps each instruction through FETCH, DECODE, EXEC, optional MEM and WB, and generates per-stage enables, ALU op and datapath controls. It adds a req/ack handshake to data memory, an instruction budget and illegal-opcode trapping.

Parameters:
MAX_INS, 43, instructions to retire before DONE; 0 means unlimited
MEM_TIMEOUT, 15, maximum cycles to wait for mem_ack before ERROR
CNT_W, 16, width of ins_count and cycle_count

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  level; leaves IDLE when high
ins  input  32  instruction from yIF, stable from the cycle after fetch_en
zero  input  1  ALU zero flag from yEX
mem_ack  input  1  data-memory access complete
boot  output  1  drives yPC INT: selects entryPoint as next PC
pc_en  output  1  one-cycle PC update strobe (yIF clock enable)
fetch_en  output  1  instruction register capture strobe
alu_op  output  3  ALU operation to yEX
alu_src, mem2reg  output  1  registered datapath controls
reg_write  output  1  one-cycle register-file write strobe
mem_req, mem_read, mem_write  output  1  data-memory request and type, held until ack
is_branch, is_jump  output  1  to yPC, valid during WB
busy, done, err  output  1  status
ins_count  output  CNT_W  retired-instruction count
cycle_count  output  CNT_W  see Optional Feature

Behaviour:
- Reset (synchronous, rst high at rising edge): state=IDLE, all outputs 0, counters 0. rst overrides all states, including MEM mid-handshake. mem_req drops on the next edge.
- States: IDLE, BOOT, FETCH, DECODE, EXEC, MEM, WB, DONE, ERROR. All outputs are registered.
- IDLE→BOOT when start=1.
- BOOT: boot=1 and pc_en=1 for exactly one cycle (PC loads entryPoint), then →FETCH.
- FETCH: fetch_en=1 for one cycle, →DECODE.
- DECODE: decode ins[6:0] and latch controls. Illegal opcode →ERROR with err=1.
- Opcode decode:
  - 0x33 R: funct3 000 with funct7[5]=0 →010; with funct7[5]=1 →110; funct3 111 →000; 110 →001; 010 →111; any other funct3 →010.
  - 0x13 addi, 0x03 lw, 0x23 sw, 0x63 branch, 0x6F jal: alu_op=010.
  - alu_src=1 for 0x13, 0x03 and 0x23.
  - mem2reg=1 only for lw.
  - Branch 0x63: alu_op=110.
- EXEC: alu_op stable. lw/sw →MEM, otherwise →WB.
- MEM: mem_req=1 and mem_read/mem_write held until the first cycle mem_ack=1, then →WB. If MEM_TIMEOUT cycles pass without ack →ERROR. An ack in the same cycle as the timeout counts as success.
- WB:
  - reg_write=1 for R, 0x13, lw and jal.
  - is_branch/is_jump driven.
  - pc_en=1.
  - ins_count increments.
  - Then →DONE if ins==32'h0 or (MAX_INS≠0 and ins_count+1==MAX_INS), else →FETCH.
- Cycle counts: non-memory instruction takes 4 cycles (F,D,E,W). Memory instruction takes 5 + wait cycles.
- DONE and ERROR hold until rst; busy=0 there. busy=1 in BOOT through WB.
- ins_count saturates at all-ones.
- start is ignored outside IDLE.

Optional Feature:
CPU_SEQ_CYCLE_CNT_EN:
- Defined: cycle_count increments every cycle while busy=1, saturating, cleared by rst.
- Undefined: cycle_count is tied to 0 and the counter logic is absent.

Decomposition:
- Package cpu_seq_pkg holds:
  - the state enum;
  - opcode constants (OP_R=7'h33, OP_I=7'h13, OP_LW=7'h03, OP_S=7'h23, OP_SB=7'h63, OP_JAL=7'h6F);
  - ALU op codes (ADD=010, SUB=110, AND=000, OR=001, SLT=111).
- One sub-module, cpu_seq_decode: combinational decode from ins to the control bundle and alu_op, plus the illegal flag.

Test Plan:
- Reset, then start=1 → boot and pc_en high together for 1 cycle, then fetch_en on the next cycle. All outputs were 0 during reset.
- R-type sub (funct7=0x20, funct3=0) → alu_op=110, reg_write pulses in the 4th cycle after fetch_en, ins_count=1.
- lw with mem_ack after 3 wait cycles → mem_req/mem_read high 4 cycles, mem2reg=1, reg_write in WB, total 8 cycles.
- sw with no ack → ERROR after 15 MEM cycles, err=1, mem_req low. A following rst returns to IDLE with err=0.
- Opcode 0x7F → ERROR directly from DECODE, reg_write never asserted.
- MAX_INS=3, three addi instructions → done=1 after the third WB, ins_count=3. With the macro defined, cycle_count=13.
